// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared widths, helpers and tables for the CORDIC scheduler
package cordic_pkg;
  localparam int NUM_REQ        = 4;
  localparam int FUNC_WIDTH     = 1;
  localparam int DATA_WIDTH     = 16;
  localparam int DATA_OP_WIDTH  = 18;
  localparam int NUM_DATA       = 3;
  localparam int PIPE_LAT       = 2;
  localparam int RSP_DEPTH      = 8;
  localparam int TOTAL_WIDTH    = NUM_DATA * DATA_WIDTH + FUNC_WIDTH;
  localparam int TOTAL_OP_WIDTH = NUM_DATA * DATA_OP_WIDTH + FUNC_WIDTH;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int ID_W = clog2(NUM_REQ);

  localparam int X_IDX = 0;
  localparam int Y_IDX = 1;
  localparam int Z_IDX = 2;

  // atan(2^-i) with a full turn mapped onto 2^16
  localparam logic [DATA_WIDTH-1:0] ELEM_ANGLE [16] = '{
    16'h2000, 16'h12E4, 16'h09FB, 16'h0511, 16'h028B, 16'h0146, 16'h00A3, 16'h0051,
    16'h0029, 16'h0014, 16'h000A, 16'h0005, 16'h0003, 16'h0001, 16'h0001, 16'h0000
  };

  typedef struct packed {
    logic [ID_W-1:0]           id;
    logic [TOTAL_OP_WIDTH-1:0] data;
  } rsp_entry_t;
endpackage

// File: rtl/cordic_rsp_fifo.sv
// rtl/cordic_rsp_fifo.sv - synchronous response FIFO with combinational head
module cordic_rsp_fifo
  import cordic_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // extra pointer MSB distinguishes full from empty
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/cordic_rr_scheduler.sv
// rtl/cordic_rr_scheduler.sv - round-robin sharing of one CORDIC pipeline among requesters
module cordic_rr_scheduler
  import cordic_pkg::*;
#(
  parameter int NUM_REQ       = cordic_pkg::NUM_REQ,
  parameter int FUNC_WIDTH    = cordic_pkg::FUNC_WIDTH,
  parameter int DATA_WIDTH    = cordic_pkg::DATA_WIDTH,
  parameter int DATA_OP_WIDTH = cordic_pkg::DATA_OP_WIDTH,
  parameter int NUM_DATA      = cordic_pkg::NUM_DATA,
  parameter int PIPE_LAT      = cordic_pkg::PIPE_LAT,
  parameter int RSP_DEPTH     = cordic_pkg::RSP_DEPTH,
  localparam int TOTAL_WIDTH    = NUM_DATA * DATA_WIDTH + FUNC_WIDTH,
  localparam int TOTAL_OP_WIDTH = NUM_DATA * DATA_OP_WIDTH + FUNC_WIDTH,
  localparam int ID_W           = clog2(NUM_REQ)
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_REQ-1:0]             i_req_vld,
  input  logic [NUM_REQ*TOTAL_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]             o_req_rdy,
  output logic                           o_dp_vld,
  output logic [TOTAL_WIDTH-1:0]         o_dp_data,
  input  logic                           i_dp_vld,
  input  logic [TOTAL_OP_WIDTH-1:0]      i_dp_data,
  output logic [NUM_REQ-1:0]             o_rsp_vld,
  output logic [TOTAL_OP_WIDTH-1:0]      o_rsp_data,
  input  logic [NUM_REQ-1:0]             i_rsp_rdy,
  output logic                           o_err
);
  localparam int CNT_W = clog2(RSP_DEPTH + 1);
  localparam int ENT_W = ID_W + TOTAL_OP_WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RSP_DEPTH);
  localparam logic [ID_W-1:0]  PTR_RST = ID_W'(NUM_REQ - 1);

  logic [CNT_W-1:0]   cnt;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    issue_id;
  logic [ID_W-1:0]    head_id;
  logic               grant_vld;
  logic               credit;
  logic               accept;
  logic               pop;
  logic               lost;
  logic               fifo_wr;
  logic               fifo_full;
  logic               fifo_empty;
  logic [PIPE_LAT-1:0] tag_vld;
  logic [ID_W-1:0]    tag_id [PIPE_LAT];
  logic [ENT_W-1:0]   head;

  always_comb begin : arbiter
    int idx;
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!grant_vld && i_req_vld[idx]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
  end

  // credit covers in-flight ops too, so the FIFO can always absorb every result
  assign credit    = (cnt < CNT_MAX);
  assign accept    = i_rst_n & grant_vld & credit;
  assign o_req_rdy = accept ? (NUM_REQ'(1) << grant_id) : '0;

  assign fifo_wr    = i_dp_vld & tag_vld[PIPE_LAT-1];
  assign lost       = tag_vld[PIPE_LAT-1] & ~i_dp_vld;
  assign head_id    = head[ENT_W-1 -: ID_W];
  assign pop        = ~fifo_empty & i_rsp_rdy[head_id];
  assign o_rsp_vld  = fifo_empty ? '0 : (NUM_REQ'(1) << head_id);
  assign o_rsp_data = head[TOTAL_OP_WIDTH-1:0];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_dp_vld  <= 1'b0;
      o_dp_data <= '0;
      issue_id  <= '0;
      ptr       <= PTR_RST;
      cnt       <= '0;
      tag_vld   <= '0;
      o_err     <= 1'b0;
      for (int k = 0; k < PIPE_LAT; k++) tag_id[k] <= '0;
    end else begin
      o_dp_vld <= accept;
      if (accept) begin
        o_dp_data <= i_req_data[int'(grant_id)*TOTAL_WIDTH +: TOTAL_WIDTH];
        issue_id  <= grant_id;
        ptr       <= grant_id;
      end
      // tag follows the issued op so the tail lines up with the datapath output
      tag_vld[0] <= o_dp_vld;
      tag_id[0]  <= issue_id;
      for (int k = 1; k < PIPE_LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
      end
      cnt <= cnt + CNT_W'(accept) - CNT_W'(pop) - CNT_W'(lost);
      if (i_dp_vld != tag_vld[PIPE_LAT-1]) o_err <= 1'b1;
    end
  end

  cordic_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (ENT_W)
  ) u_rsp_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .wr_en   (fifo_wr),
    .wr_data ({tag_id[PIPE_LAT-1], i_dp_data}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(fifo_wr && fifo_full))
    else $error("response fifo write while full");
endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// tb/tb_cordic_rr_scheduler.sv - self-checking bench for cordic_rr_scheduler
module tb_cordic_rr_scheduler;
  localparam int NUM_REQ   = 4;
  localparam int PIPE_LAT  = 2;
  localparam int RSP_DEPTH = 8;
  localparam int TW        = 3 * 16 + 1;
  localparam int OW        = 3 * 18 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n;
  logic [NUM_REQ-1:0]     req_vld, req_rdy, rsp_vld, rsp_rdy;
  logic [NUM_REQ*TW-1:0]  req_data;
  logic                   dp_vld_o, dp_vld_i, err;
  logic [TW-1:0]          dp_data_o;
  logic [OW-1:0]          dp_data_i, rsp_data;

  int checks = 0;
  int fails  = 0;

  cordic_rr_scheduler dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req_vld  (req_vld),
    .i_req_data (req_data),
    .o_req_rdy  (req_rdy),
    .o_dp_vld   (dp_vld_o),
    .o_dp_data  (dp_data_o),
    .i_dp_vld   (dp_vld_i),
    .i_dp_data  (dp_data_i),
    .o_rsp_vld  (rsp_vld),
    .o_rsp_data (rsp_data),
    .i_rsp_rdy  (rsp_rdy),
    .o_err      (err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: issued-op list, result queue, credit total
  typedef struct {int cyc; int id;} flight_t;
  typedef struct {int id; logic [OW-1:0] data;} ent_t;
  flight_t m_flight[$];
  ent_t    m_fifo[$];
  int      m_last = NUM_REQ - 1;
  int      m_cnt  = 0;
  int      cyc    = 0;
  logic    m_err  = 1'b0;
  logic    m_dp_vld = 1'b0;
  logic [TW-1:0] m_dp_data = '0;

  always @(negedge clk) begin : model
    int g, tag_id;
    bit acc, pop, tag, lost;
    flight_t f;
    logic [NUM_REQ-1:0] exp_rdy, exp_rsp;
    g = -1;
    for (int i = 1; i <= NUM_REQ; i++)
      if (g < 0 && req_vld[(m_last + i) % NUM_REQ]) g = (m_last + i) % NUM_REQ;
    exp_rdy = (rst_n && g >= 0 && m_cnt < RSP_DEPTH) ? (NUM_REQ'(1) << g) : '0;
    exp_rsp = (m_fifo.size() > 0) ? (NUM_REQ'(1) << m_fifo[0].id) : '0;
    chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
    chk("dp_vld", 64'(dp_vld_o), 64'(m_dp_vld));
    chk("dp_data", 64'(dp_data_o), 64'(m_dp_data));
    chk("rsp_vld", 64'(rsp_vld), 64'(exp_rsp));
    if (m_fifo.size() > 0) chk("rsp_data", 64'(rsp_data), 64'(m_fifo[0].data));
    chk("err", 64'(err), 64'(m_err));
    if (!rst_n) begin
      m_flight.delete();
      m_fifo.delete();
      m_last = NUM_REQ - 1;
      m_cnt = 0;
      m_err = 1'b0;
      m_dp_vld = 1'b0;
      m_dp_data = '0;
    end else begin
      acc = (exp_rdy != 0);
      pop = (m_fifo.size() > 0) && rsp_rdy[m_fifo[0].id];
      tag = 1'b0;
      tag_id = 0;
      while (m_flight.size() > 0 && m_flight[0].cyc < cyc - 1 - PIPE_LAT) void'(m_flight.pop_front());
      if (m_flight.size() > 0 && m_flight[0].cyc == cyc - 1 - PIPE_LAT) begin
        f = m_flight.pop_front();
        tag = 1'b1;
        tag_id = f.id;
      end
      if (pop) void'(m_fifo.pop_front());
      if (tag && dp_vld_i) m_fifo.push_back('{tag_id, dp_data_i});
      if (tag != dp_vld_i) m_err = 1'b1;
      lost = tag && !dp_vld_i;
      m_cnt = m_cnt + int'(acc) - int'(pop) - int'(lost);
      m_dp_vld = acc;
      if (acc) begin
        m_last = g;
        m_flight.push_back('{cyc, g});
        m_dp_data = req_data[g*TW +: TW];
      end
    end
    cyc++;
  end

  // Stub datapath: PIPE_LAT-cycle delay of the issued op, result tagged in its top bits
  logic          dly_vld  [PIPE_LAT];
  logic [TW-1:0] dly_data [PIPE_LAT];

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      logic          cv;
      logic [TW-1:0] cd;
      cv = dp_vld_o;
      cd = dp_data_o;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        for (int j = 0; j < PIPE_LAT; j++) begin dly_vld[j] = 1'b0; dly_data[j] = '0; end
      end else begin
        for (int j = PIPE_LAT - 1; j > 0; j--) begin dly_vld[j] = dly_vld[j-1]; dly_data[j] = dly_data[j-1]; end
        dly_vld[0]  = cv;
        dly_data[0] = cd;
      end
      dp_vld_i  = dly_vld[PIPE_LAT-1];
      dp_data_i = {6'h2A, dly_data[PIPE_LAT-1]};
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    rst_n = 1'b0; req_vld = '0; req_data = '0; rsp_rdy = '0;
    dp_vld_i = 1'b0; dp_data_i = '0;
    for (int j = 0; j < PIPE_LAT; j++) begin dly_vld[j] = 1'b0; dly_data[j] = '0; end
    step(2);
    req_vld = '1;
    #1;
    chk("rst_rdy", 64'(req_rdy), 64'h0);
    chk("rst_dp_vld", 64'(dp_vld_o), 64'h0);
    chk("rst_dp_data", 64'(dp_data_o), 64'h0);
    chk("rst_rsp_vld", 64'(rsp_vld), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    req_vld = '0; rst_n = 1'b1; rsp_rdy = '1;

    // single request from requester 2
    req_data[2*TW +: TW] = 49'h1_1234_5678_9ABC;
    req_vld = 4'b0100;
    #1;
    chk("t1_rdy", 64'(req_rdy), 64'h4);
    step(1);
    req_vld = '0;
    chk("t1_dp_vld", 64'(dp_vld_o), 64'h1);
    chk("t1_dp_data", 64'(dp_data_o), 64'h1_1234_5678_9ABC);
    step(2);
    chk("t1_rsp_early", 64'(rsp_vld), 64'h0);
    step(1);
    chk("t1_rsp_vld", 64'(rsp_vld), 64'h4);
    chk("t1_rsp_data", 64'(rsp_data), 64'h55_1234_5678_9ABC);
    step(1);
    chk("t1_drained", 64'(rsp_vld), 64'h0);

    // round robin from reset
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    req_vld = '1;
    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < NUM_REQ; r++) req_data[r*TW +: TW] = TW'(i * 16 + r + 1);
      #1;
      chk("rr_grant", 64'(req_rdy), 64'(1 << (i % 4)));
      step(1);
    end
    req_vld = '0;
    step(6);

    // backpressure: exactly RSP_DEPTH accepts, then one accept per pop
    rsp_rdy = '0; req_vld = 4'b0001; acc = 0;
    for (int i = 0; i < 12; i++) begin
      req_data[0 +: TW] = TW'(100 + i);
      #1;
      if (req_rdy[0]) acc++;
      step(1);
    end
    chk("bp_accepts", 64'(acc), 64'd8);
    rsp_rdy = '1;
    #1;
    chk("bp_no_bypass", 64'(req_rdy), 64'h0);
    step(1);
    for (int i = 0; i < 4; i++) begin
      req_data[0 +: TW] = TW'(200 + i);
      #1;
      chk("cnt7_accept", 64'(req_rdy), 64'h1);
      step(1);
    end
    rsp_rdy = '0;
    req_data[0 +: TW] = TW'(250);
    #1;
    chk("cnt7_last", 64'(req_rdy), 64'h1);
    step(1);
    #1;
    chk("cnt8_full", 64'(req_rdy), 64'h0);
    req_vld = '0; rsp_rdy = '1;
    step(14);

    // reset with 3 in flight and 2 queued
    rsp_rdy = '0; req_vld = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      req_data[0 +: TW] = TW'(300 + i);
      step(1);
    end
    req_vld = '0;
    chk("mr_queued", 64'(rsp_vld), 64'h1);
    rst_n = 1'b0;
    step(1);
    req_vld = '1;
    #1;
    chk("mr_rdy", 64'(req_rdy), 64'h0);
    chk("mr_dp_vld", 64'(dp_vld_o), 64'h0);
    chk("mr_dp_data", 64'(dp_data_o), 64'h0);
    chk("mr_rsp_vld", 64'(rsp_vld), 64'h0);
    chk("mr_err", 64'(err), 64'h0);
    rst_n = 1'b1; rsp_rdy = '1;
    #1;
    chk("mr_first_grant", 64'(req_rdy), 64'h1);
    step(1);
    req_vld = '0;
    step(8);

    // result with no tag: sticky error, nothing queued
    dp_vld_i = 1'b1;
    dp_data_i = OW'(7);
    step(1);
    chk("err_set", 64'(err), 64'h1);
    chk("err_no_write", 64'(rsp_vld), 64'h0);
    step(3);
    chk("err_sticky", 64'(err), 64'h1);
    chk("err_still_empty", 64'(rsp_vld), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
